conv_kxk_mac_seq: RTL



---
 rtl/conv_kxk_mac_seq.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/conv_kxk_mac_seq.sv
// rtl/conv_kxk_mac_seq.sv - KxK window MAC, LANES multipliers time-multiplexed, shift/ReLU/saturate output
module conv_kxk_mac_seq #(
    parameter int K     = 3,
    parameter int PIX_W = 8,
    parameter int W_W   = 18,
    parameter int LANES = 2,
    parameter int OUT_W = 19,
    parameter int SHIFT = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [$clog2(K*K)-1:0]    wr_addr,
    input  logic [W_W-1:0]            wr_data,
    output logic                      wr_err,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [K*K*PIX_W-1:0]      in_pix,
    input  logic                      relu_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic                      busy
);

    localparam int NTAP   = K * K;
    localparam int AW     = $clog2(NTAP);
    localparam int ACC_W  = PIX_W + W_W + 1 + $clog2(NTAP);
    localparam int PROD_W = PIX_W + 1 + W_W;
    // idx runs past NTAP by up to LANES-1 on the last pass, so size it for that
    localparam int IW     = $clog2(NTAP + LANES + 1);
    // clamp comparison width: wide enough for both the accumulator and the output range
    localparam int CW     = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic signed [CW-1:0] SAT_MAX = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [CW-1:0] SAT_MIN = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [1:0]                state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      out_valid_q, out_valid_d;
    logic [OUT_W-1:0]          out_data_q, out_data_d;
    logic                      wr_err_q;
    logic                      relu_q;
    logic [PIX_W-1:0]          pix_q    [NTAP];
    logic signed [W_W-1:0]     weight_q [NTAP];

    logic [PIX_W-1:0]          lane_pix  [LANES];
    logic signed [W_W-1:0]     lane_w    [LANES];
    logic signed [PROD_W-1:0]  lane_prod [LANES];
    logic signed [ACC_W-1:0]   lane_sum;
    logic signed [ACC_W-1:0]   final_sum;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [CW-1:0]      clamp_in;
    logic [OUT_W-1:0]          post_val;
    logic                      accept;
    logic                      last_pass;
    logic                      wr_ok;

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign accept    = in_valid && in_ready;
    assign last_pass = ((idx_q + IW'(LANES)) >= IW'(NTAP));
    assign wr_ok     = wr_en && (state_q == S_IDLE) && ({1'b0, wr_addr} < (AW+1)'(NTAP));

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign wr_err    = wr_err_q;

    // Route taps idx..idx+LANES-1 to the lane multipliers; taps past the window read as zero
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_pix[l] = '0;
            lane_w[l]   = '0;
            for (int t = 0; t < NTAP; t++) begin
                if ((idx_q + IW'(l)) == IW'(t)) begin
                    lane_pix[l] = pix_q[t];
                    lane_w[l]   = weight_q[t];
                end
            end
            lane_prod[l] = $signed({1'b0, lane_pix[l]}) * lane_w[l];
        end
    end

    // Sum this cycle's lane products and post-process the would-be final sum
    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_sum = lane_sum + ACC_W'(lane_prod[l]);
        end
        final_sum = acc_q + lane_sum;
        shifted   = final_sum >>> SHIFT;
        if (relu_q && (shifted < 0)) begin
            shifted = '0;
        end
        clamp_in = CW'(shifted);
        if (clamp_in > SAT_MAX) begin
            post_val = SAT_MAX[OUT_W-1:0];
        end else if (clamp_in < SAT_MIN) begin
            post_val = SAT_MIN[OUT_W-1:0];
        end else begin
            post_val = clamp_in[OUT_W-1:0];
        end
    end

    // Control FSM: accept a window, accumulate NB passes, then hold the result until taken
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ACC;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            S_ACC: begin
                acc_d = final_sum;
                idx_d = idx_q + IW'(LANES);
                if (last_pass) begin
                    state_d     = S_OUT;
                    out_valid_d = 1'b1;
                    out_data_d  = post_val;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath and FSM state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Capture the window and its ReLU mode on the accept edge only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            relu_q <= 1'b0;
            for (int t = 0; t < NTAP; t++) begin
                pix_q[t] <= '0;
            end
        end else if (accept) begin
            relu_q <= relu_en;
            for (int t = 0; t < NTAP; t++) begin
                pix_q[t] <= in_pix[t*PIX_W +: PIX_W];
            end
        end
    end

    // Weight bank: writes land only in IDLE with a valid tap, anything else flags wr_err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_q <= 1'b0;
            for (int t = 0; t < NTAP; t++) begin
                weight_q[t] <= '0;
            end
        end else begin
            wr_err_q <= wr_en && !wr_ok;
            for (int t = 0; t < NTAP; t++) begin
                if (wr_ok && (wr_addr == AW'(t))) begin
                    weight_q[t] <= wr_data;
                end
            end
        end
    end

endmodule
